pu_riscv_writeback: RTL and testbench

Write-back stage of the PU-RISCV core pipeline. It sits directly downstream of the memory-access stage and consumes its outputs: `mem_pc`, `mem_instr`, `mem_bubble`, `mem_exception`, `mem_r` and `mem_memadr`. It also takes the data-memory response. For loads it aligns and sign- or zero-extends the returned data, and it waits for outstanding loads while stalling the pipeline. It registers the final result, destination and exception vector for the register file and the state/exception unit.

---
 rtl/pu_riscv_verilog_pkg.sv | 32 +++
 rtl/pu_riscv_load_align.sv | 29 ++
 rtl/pu_riscv_writeback.sv | 141 ++++++++++++++
 tb/tb_pu_riscv_writeback.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_riscv_verilog_pkg.sv
// Shared PU-RISCV constants: opcodes, load funct3 codes, exception causes and
// the write-back FSM state type.
package pu_riscv_verilog_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int unsigned CAUSE_ILLEGAL_INSTRUCTION = 2;
  localparam int unsigned CAUSE_MISALIGNED_LOAD     = 4;
  localparam int unsigned CAUSE_LOAD_ACCESS_FAULT   = 5;
  localparam int unsigned CAUSE_LOAD_PAGE_FAULT     = 13;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/pu_riscv_load_align.sv
// Load data alignment: shifts the raw bus word down to the addressed byte and
// sign- or zero-extends it according to the load width.
module pu_riscv_load_align
  import pu_riscv_verilog_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   byte_off,
  input  logic [XLEN-1:0]             raw,
  output logic [XLEN-1:0]             data
);

  logic [XLEN-1:0] shifted;

  always_comb begin : align_extend
    shifted = raw >> {byte_off, 3'b000};
    case (funct3)
      LB:      data = XLEN'($signed(shifted[7:0]));
      LH:      data = XLEN'($signed(shifted[15:0]));
      LW:      data = XLEN'($signed(shifted[31:0]));
      LBU:     data = XLEN'(shifted[7:0]);
      LHU:     data = XLEN'(shifted[15:0]);
      LWU:     data = XLEN'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/pu_riscv_writeback.sv
// PU-RISCV write-back stage: retires memory-stage results, waits for load
// responses while stalling the pipeline, and folds load faults into the exception vector.
module pu_riscv_writeback
  import pu_riscv_verilog_pkg::*;
#(
  parameter int unsigned     XLEN           = 64,
  parameter int unsigned     ILEN           = 64,
  parameter int unsigned     EXCEPTION_SIZE = 16,
  parameter logic [XLEN-1:0] PC_INIT        = XLEN'(32'h8000_0000)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           mem_pc,
  input  logic [ILEN-1:0]           mem_instr,
  input  logic                      mem_bubble,
  input  logic [EXCEPTION_SIZE-1:0] mem_exception,
  input  logic [XLEN-1:0]           mem_r,
  input  logic [XLEN-1:0]           mem_memadr,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      dmem_err,
  input  logic                      dmem_page_fault,
  output logic                      wb_stall,
  output logic [XLEN-1:0]           wb_pc,
  output logic [ILEN-1:0]           wb_instr,
  output logic                      wb_bubble,
  output logic [EXCEPTION_SIZE-1:0] wb_exception,
  output logic [XLEN-1:0]           wb_r,
  output logic [4:0]                wb_dst,
  output logic                      wb_we
);

  localparam int unsigned OFF_W = $clog2(XLEN/8);

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [4:0]                rd;
  wb_state_e                 state, state_nxt;
  logic                      valid_load, illegal, misaligned, needs_mem, resp;
  logic                      no_write_opc, we_nxt;
  logic [XLEN-1:0]           load_data, r_nxt;
  logic [EXCEPTION_SIZE-1:0] new_exc, exc_nxt;
  logic                      unused_bits;

  assign opcode      = mem_instr[6:0];
  assign funct3      = mem_instr[14:12];
  assign rd          = mem_instr[11:7];
  assign unused_bits = ^{mem_instr[ILEN-1:15], mem_memadr[XLEN-1:3]};

  pu_riscv_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3   (funct3),
    .byte_off (mem_memadr[OFF_W-1:0]),
    .raw      (dmem_q),
    .data     (load_data)
  );

  // Classify the memory-stage slot: only aligned, legal, fault-free loads touch dmem
  always_comb begin : classify
    valid_load = (opcode == OPC_LOAD) && !mem_bubble && (mem_exception == '0);
    illegal    = valid_load && (XLEN == 32) && ((funct3 == LD) || (funct3 == LWU));
    misaligned = 1'b0;
    if (valid_load && !illegal) begin
      case (funct3)
        LH, LHU: misaligned = mem_memadr[0];
        LW, LWU: misaligned = |mem_memadr[1:0];
        LD:      misaligned = |mem_memadr[2:0];
        default: misaligned = 1'b0;
      endcase
    end
    needs_mem = valid_load && !illegal && !misaligned;
    resp      = dmem_ack | dmem_err | dmem_page_fault;
  end

  // Next state and the combinational stall
  always_comb begin : fsm_next
    state_nxt = state;
    wb_stall  = 1'b0;
    case (state)
      ST_RUN: begin
        if (needs_mem && !resp) begin
          state_nxt = ST_WAIT;
          wb_stall  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (resp) state_nxt = ST_RUN;
        else      wb_stall  = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Page fault beats data, data beats bus error
  always_comb begin : result
    new_exc = '0;
    r_nxt   = mem_r;
    if (illegal)    new_exc[CAUSE_ILLEGAL_INSTRUCTION] = 1'b1;
    if (misaligned) new_exc[CAUSE_MISALIGNED_LOAD]     = 1'b1;
    if (needs_mem) begin
      if (dmem_page_fault) new_exc[CAUSE_LOAD_PAGE_FAULT] = 1'b1;
      else if (dmem_ack)   r_nxt = load_data;
      else if (dmem_err)   new_exc[CAUSE_LOAD_ACCESS_FAULT] = 1'b1;
    end
    exc_nxt      = mem_bubble ? '0 : (mem_exception | new_exc);
    no_write_opc = (opcode == OPC_STORE) || (opcode == OPC_BRANCH) ||
                   (opcode == OPC_MISC_MEM) ||
                   ((opcode == OPC_SYSTEM) && (funct3 == 3'b000));
    we_nxt       = (rd != 5'd0) && !mem_bubble && (exc_nxt == '0) && !no_write_opc;
  end

  always_ff @(posedge clk or negedge rstn) begin : state_reg
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Retire registers; a stall cycle retires a bubble
  always_ff @(posedge clk or negedge rstn) begin : wb_reg
    if (!rstn) begin
      wb_pc        <= PC_INIT;
      wb_instr     <= ILEN'(INSTR_NOP);
      wb_bubble    <= 1'b1;
      wb_exception <= '0;
      wb_r         <= '0;
      wb_dst       <= 5'd0;
      wb_we        <= 1'b0;
    end else if (wb_stall) begin
      wb_bubble    <= 1'b1;
      wb_exception <= '0;
      wb_we        <= 1'b0;
    end else begin
      wb_pc        <= mem_pc;
      wb_instr     <= mem_instr;
      wb_bubble    <= mem_bubble;
      wb_exception <= exc_nxt;
      wb_r         <= r_nxt;
      wb_dst       <= rd;
      wb_we        <= we_nxt;
    end
  end

endmodule

// File: tb/tb_pu_riscv_writeback.sv
// Self-checking bench for pu_riscv_writeback: directed scenarios plus randomized
// transactions checked against a behavioural model of the write-back rules.
module tb_pu_riscv_writeback;

  localparam logic [63:0] PC_INIT = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] r;
    logic [15:0] exc;
    logic        we;
    logic        mem;
  } exp_t;

  logic        clk, rstn;
  logic [63:0] mem_pc, mem_instr, mem_r, mem_memadr, dmem_q;
  logic        mem_bubble, dmem_ack, dmem_err, dmem_page_fault;
  logic [15:0] mem_exception;
  logic        wb_stall, wb_bubble, wb_we;
  logic [63:0] wb_pc, wb_instr, wb_r;
  logic [15:0] wb_exception;
  logic [4:0]  wb_dst;

  int n_cmp = 0;
  int n_err = 0;

  pu_riscv_writeback dut (
    .clk             (clk),
    .rstn            (rstn),
    .mem_pc          (mem_pc),
    .mem_instr       (mem_instr),
    .mem_bubble      (mem_bubble),
    .mem_exception   (mem_exception),
    .mem_r           (mem_r),
    .mem_memadr      (mem_memadr),
    .dmem_ack        (dmem_ack),
    .dmem_q          (dmem_q),
    .dmem_err        (dmem_err),
    .dmem_page_fault (dmem_page_fault),
    .wb_stall        (wb_stall),
    .wb_pc           (wb_pc),
    .wb_instr        (wb_instr),
    .wb_bubble       (wb_bubble),
    .wb_exception    (wb_exception),
    .wb_r            (wb_r),
    .wb_dst          (wb_dst),
    .wb_we           (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk_instr(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [31:0] hi);
    mk_instr = {32'h0, hi[31:15], f3, rd, op};
  endfunction

  // Reference: load size from funct3, alignment by modulo, extension by masking
  function automatic exp_t model(input logic [63:0] instr, input logic bubble,
                                 input logic [15:0] exc, input logic [63:0] r,
                                 input logic [63:0] addr, input logic [63:0] q,
                                 input logic ack, input logic err, input logic pf);
    exp_t m;
    logic [6:0] op;
    logic [2:0] f3;
    logic [15:0] newe;
    longint unsigned v, mask, size;
    op = instr[6:0];
    f3 = instr[14:12];
    newe = 16'h0;
    m.r = r;
    m.mem = 1'b0;
    if (op == 7'h03 && !bubble && exc == 16'h0) begin
      size = 64'd1 << (f3 % 3'd4);
      if ((addr % size) != 0) newe[4] = 1'b1;
      else begin
        m.mem = 1'b1;
        if (pf) newe[13] = 1'b1;
        else if (ack) begin
          v = q >> (8 * (addr % 8));
          if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v = v & mask;
            if (f3 < 3'd4 && ((v >> (8 * size - 1)) & 64'd1) == 64'd1) v = v | ~mask;
          end
          m.r = v;
        end else if (err) newe[5] = 1'b1;
      end
    end
    m.exc = bubble ? 16'h0 : (exc | newe);
    m.we = (instr[11:7] != 5'd0) && !bubble && (m.exc == 16'h0) &&
           (op != 7'h23) && (op != 7'h63) && (op != 7'h0f) &&
           !(op == 7'h73 && f3 == 3'd0);
    return m;
  endfunction

  // Present one slot, hold it through `waits` silent cycles, then apply the response
  task automatic drive_txn(input logic [63:0] pc, input logic [63:0] instr, input logic bubble,
                           input logic [15:0] exc, input logic [63:0] r, input logic [63:0] addr,
                           input logic [63:0] q, input int waits, input logic ack,
                           input logic err, input logic pf,
                           output int stall_seen, output int bub_seen);
    mem_pc = pc; mem_instr = instr; mem_bubble = bubble;
    mem_exception = exc; mem_r = r; mem_memadr = addr;
    stall_seen = 0;
    bub_seen = 0;
    for (int c = 0; c <= waits; c++) begin
      dmem_q          = (c == waits) ? q : {$urandom(), $urandom()};
      dmem_ack        = (c == waits) ? ack : 1'b0;
      dmem_err        = (c == waits) ? err : 1'b0;
      dmem_page_fault = (c == waits) ? pf : 1'b0;
      #1;
      if (wb_stall) stall_seen++;
      @(posedge clk); #1;
      if (c < waits && wb_bubble && !wb_we) bub_seen++;
    end
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_page_fault = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mem_bubble = 1'b1; mem_instr = 64'h13; mem_exception = 16'h0;
    mem_pc = 64'h0; mem_r = 64'h0; mem_memadr = 64'h0; dmem_q = 64'h0;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_page_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wb_pc !== PC_INIT) begin n_err++; $display("FAIL reset_pc: got %h exp %h", wb_pc, PC_INIT); end
    n_cmp++; if (wb_instr !== 64'h13) begin n_err++; $display("FAIL reset_instr: got %h exp %h", wb_instr, 64'h13); end
    n_cmp++; if (wb_bubble !== 1'b1) begin n_err++; $display("FAIL reset_bubble: got %b exp 1", wb_bubble); end
    n_cmp++; if (wb_exception !== 16'h0) begin n_err++; $display("FAIL reset_exc: got %h exp 0", wb_exception); end
    n_cmp++; if (wb_r !== 64'h0) begin n_err++; $display("FAIL reset_r: got %h exp 0", wb_r); end
    n_cmp++; if (wb_dst !== 5'd0) begin n_err++; $display("FAIL reset_dst: got %0d exp 0", wb_dst); end
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b exp 0", wb_we); end
    n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", wb_stall); end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    int st, bb;
    drive_txn(64'h8000_0100, mk_instr(7'h13, 3'd0, 5'd5, 32'h0010_0000), 1'b0, 16'h0,
              64'h1234, 64'h0, 64'hDEAD, 0, 1'b1, 1'b0, 1'b0, st, bb);
    n_cmp++; if (wb_r !== 64'h1234) begin n_err++; $display("FAIL addi_r: got %h exp 1234", wb_r); end
    n_cmp++; if (wb_dst !== 5'd5) begin n_err++; $display("FAIL addi_dst: got %0d exp 5", wb_dst); end
    n_cmp++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL addi_we: got %b exp 1", wb_we); end
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL addi_stall: got %0d cycles exp 0", st); end
    n_cmp++; if (wb_pc !== 64'h8000_0100) begin n_err++; $display("FAIL addi_pc: got %h exp 80000100", wb_pc); end
  endtask

  task automatic test_lb_wait();
    int st, bb;
    drive_txn(64'h8000_0104, mk_instr(7'h03, 3'd0, 5'd6, 32'h0), 1'b0, 16'h0, 64'h0,
              64'h0000_1000_0000_0003, 64'h0000_0000_80FF_0000, 2, 1'b1, 1'b0, 1'b0, st, bb);
    n_cmp++; if (st !== 2) begin n_err++; $display("FAIL lb_stall: got %0d cycles exp 2", st); end
    n_cmp++; if (bb !== 2) begin n_err++; $display("FAIL lb_bubble_ins: got %0d cycles exp 2", bb); end
    n_cmp++; if (wb_r !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_r: got %h exp ffffffffffffff80", wb_r); end
    n_cmp++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL lb_we: got %b exp 1", wb_we); end
  endtask

  task automatic test_lhu_zero_wait();
    int st, bb;
    drive_txn(64'h8000_0108, mk_instr(7'h03, 3'd5, 5'd7, 32'h0), 1'b0, 16'h0, 64'h0,
              64'h0000_2000_0000_0006, 64'hBEEF_0000_0000_0000, 0, 1'b1, 1'b0, 1'b0, st, bb);
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL lhu_stall: got %0d cycles exp 0", st); end
    n_cmp++; if (wb_r !== 64'h0000_0000_0000_BEEF) begin n_err++; $display("FAIL lhu_r: got %h exp beef", wb_r); end
  endtask

  task automatic test_lw_misaligned();
    int st, bb;
    drive_txn(64'h8000_010c, mk_instr(7'h03, 3'd2, 5'd8, 32'h0), 1'b0, 16'h0, 64'h55,
              64'h0000_3000_0000_0002, 64'h1111_2222_3333_4444, 0, 1'b1, 1'b1, 1'b0, st, bb);
    n_cmp++; if (wb_exception !== 16'h0010) begin n_err++; $display("FAIL lw_mis_exc: got %h exp 0010", wb_exception); end
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL lw_mis_we: got %b exp 0", wb_we); end
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL lw_mis_stall: got %0d cycles exp 0", st); end
  endtask

  task automatic test_ld_faults();
    int st, bb;
    drive_txn(64'h8000_0110, mk_instr(7'h03, 3'd3, 5'd9, 32'h0), 1'b0, 16'h0, 64'h0,
              64'h0000_4000_0000_0008, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b1, 1'b1, st, bb);
    n_cmp++; if (wb_exception !== 16'h2000) begin n_err++; $display("FAIL ld_fault_exc: got %h exp 2000", wb_exception); end
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL ld_fault_we: got %b exp 0", wb_we); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL ld_fault_stall: got %0d cycles exp 1", st); end
  endtask

  task automatic test_reset_in_wait();
    int st, bb;
    mem_pc = 64'h8000_0200; mem_instr = mk_instr(7'h03, 3'd2, 5'd10, 32'h0);
    mem_bubble = 1'b0; mem_exception = 16'h0; mem_r = 64'h0; mem_memadr = 64'h40;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_page_fault = 1'b0;
    #1;
    n_cmp++; if (wb_stall !== 1'b1) begin n_err++; $display("FAIL rstwait_stall_run: got %b exp 1", wb_stall); end
    @(posedge clk); #1;
    n_cmp++; if (wb_stall !== 1'b1) begin n_err++; $display("FAIL rstwait_stall_wait: got %b exp 1", wb_stall); end
    rstn = 1'b0; mem_bubble = 1'b1;
    #1;
    n_cmp++; if (wb_pc !== PC_INIT) begin n_err++; $display("FAIL rstwait_pc: got %h exp %h", wb_pc, PC_INIT); end
    n_cmp++; if (wb_bubble !== 1'b1) begin n_err++; $display("FAIL rstwait_bubble: got %b exp 1", wb_bubble); end
    n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL rstwait_stall_rst: got %b exp 0", wb_stall); end
    @(negedge clk) rstn = 1'b1;
    drive_txn(64'h8000_0200, mk_instr(7'h03, 3'd2, 5'd10, 32'h0), 1'b1, 16'h0, 64'h0,
              64'h40, 64'h7777_7777_7777_7777, 0, 1'b1, 1'b0, 1'b0, st, bb);
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL rstwait_we: got %b exp 0", wb_we); end
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL rstwait_stall_after: got %0d cycles exp 0", st); end
    n_cmp++; if (wb_exception !== 16'h0) begin n_err++; $display("FAIL rstwait_exc: got %h exp 0", wb_exception); end
    #1;
    n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL rstwait_fsm_run: got %b exp 0", wb_stall); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [8];
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] instr, pc, r, addr, q;
    logic [15:0] exc;
    logic        bub, ack, err, pf;
    int          waits, kind, st, bb;
    exp_t        m;
    ops = '{7'h13, 7'h33, 7'h37, 7'h23, 7'h63, 7'h0f, 7'h73, 7'h03};
    for (int i = 0; i < 300; i++) begin
      op    = ($urandom_range(0, 1) == 0) ? 7'h03 : ops[$urandom_range(0, 7)];
      f3    = (op == 7'h03) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
      rd    = 5'($urandom_range(0, 31));
      instr = mk_instr(op, f3, rd, $urandom());
      pc    = {$urandom(), $urandom()};
      r     = {$urandom(), $urandom()};
      addr  = {$urandom(), $urandom()};
      q     = {$urandom(), $urandom()};
      bub   = ($urandom_range(0, 7) == 0);
      exc   = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'h0;
      kind  = $urandom_range(0, 5);
      ack   = (kind <= 2) || (kind == 4);
      err   = (kind == 3) || (kind == 4) || (kind == 5);
      pf    = (kind == 5) || (kind == 2 && $urandom_range(0, 1) == 1);
      if (kind == 2) begin ack = 1'b0; pf = 1'b1; end
      m = model(instr, bub, exc, r, addr, q, ack, err, pf);
      waits = m.mem ? $urandom_range(0, 3) : 0;
      drive_txn(pc, instr, bub, exc, r, addr, q, waits, ack, err, pf, st, bb);
      n_cmp++; if (st !== waits) begin n_err++; $display("FAIL rnd%0d_stall: got %0d exp %0d", i, st, waits); end
      n_cmp++; if (wb_exception !== m.exc) begin n_err++; $display("FAIL rnd%0d_exc: got %h exp %h", i, wb_exception, m.exc); end
      n_cmp++; if (wb_we !== m.we) begin n_err++; $display("FAIL rnd%0d_we: got %b exp %b", i, wb_we, m.we); end
      if (m.we) begin
        n_cmp++; if (wb_r !== m.r) begin n_err++; $display("FAIL rnd%0d_r: got %h exp %h", i, wb_r, m.r); end
      end
      n_cmp++; if (wb_dst !== rd) begin n_err++; $display("FAIL rnd%0d_dst: got %0d exp %0d", i, wb_dst, rd); end
      n_cmp++; if (wb_pc !== pc) begin n_err++; $display("FAIL rnd%0d_pc: got %h exp %h", i, wb_pc, pc); end
      n_cmp++; if (wb_bubble !== bub) begin n_err++; $display("FAIL rnd%0d_bubble: got %b exp %b", i, wb_bubble, bub); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lb_wait();
    test_lhu_zero_wait();
    test_lw_misaligned();
    test_ld_faults();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
